fifo_demux_1_16: RTL

//  Write side of the 16-entry FIFO. Steers one incoming word into one of 16 entry registers,

---
 rtl/fifo_demux_1_16_pkg.sv | 16 +
 rtl/fifo_dec_4_16.sv | 21 ++
 rtl/fifo_demux_1_16.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fifo_demux_1_16_pkg.sv
// rtl/fifo_demux_1_16_pkg.sv - shared FIFO geometry and pointer helper
// Purpose : depth, pointer and count widths shared by the write-side demux
//           and the read-side mux, plus the modulo-depth pointer increment.
// Ports   : none (package)
package fifo_demux_1_16_pkg;

    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_PTR_W = 4;
    localparam int FIFO_CNT_W = 5;

    // Pointer width equals log2(depth), so natural overflow gives 15 -> 0.
    function automatic logic [FIFO_PTR_W-1:0] ptr_inc(input logic [FIFO_PTR_W-1:0] p);
        return p + FIFO_PTR_W'(1);
    endfunction

endpackage

// File: rtl/fifo_dec_4_16.sv
// rtl/fifo_dec_4_16.sv - 4-to-16 one-hot decoder with enable
// Purpose : turns a pointer plus an accept strobe into a per-entry strobe.
// Ports   : idx    in  4   entry index
//           en     in  1   strobe; all outputs 0 when low
//           onehot out 16  onehot[idx] = en
module fifo_dec_4_16
    import fifo_demux_1_16_pkg::*;
(
    input  logic [FIFO_PTR_W-1:0] idx,
    input  logic                  en,
    output logic [FIFO_DEPTH-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fifo_demux_1_16.sv
// rtl/fifo_demux_1_16.sv - write side of a 16-entry FIFO with occupancy tracking
// Purpose : steers each accepted write into the entry at wr_ptr, tracks which
//           entries hold unread data, and exposes all entries plus rd_ptr so the
//           downstream 16:1 mux can present the head entry.
// Ports   : clk, reset (async, active-high)
//           wr, in        write request and data (accepted when !full)
//           rd            pop request (accepted when !empty)
//           out_flat      entry k on bits [(k+1)*W-1 : k*W]
//           valid         per-entry unread flag
//           rd_ptr/wr_ptr head index / next write index
//           count         occupancy 0..16; full/empty decoded from it
//           overflow      sticky, set by a write attempt while full
module fifo_demux_1_16
    import fifo_demux_1_16_pkg::*;
#(
    parameter int bw   = 4,
    parameter int simd = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr,
    input  logic [simd*bw-1:0]         in,
    input  logic                       rd,
    output logic [FIFO_DEPTH*simd*bw-1:0] out_flat,
    output logic [FIFO_DEPTH-1:0]      valid,
    output logic [FIFO_PTR_W-1:0]      rd_ptr,
    output logic [FIFO_PTR_W-1:0]      wr_ptr,
    output logic [FIFO_CNT_W-1:0]      count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);

    localparam int W = simd * bw;

    logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_CNT_W-1:0] count_q, count_d;
    logic [FIFO_DEPTH-1:0] valid_q, valid_d;
    logic                  overflow_q, overflow_d;

    logic                  wr_acc, rd_acc;
    logic [FIFO_DEPTH-1:0] wr_en, rd_clr;

    // Accept decisions use pre-edge state only.
    assign full   = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty  = (count_q == '0);
    assign wr_acc = wr & ~full;
    assign rd_acc = rd & ~empty;

    fifo_dec_4_16 u_wr_dec (
        .idx    (wr_ptr_q),
        .en     (wr_acc),
        .onehot (wr_en)
    );

    fifo_dec_4_16 u_rd_dec (
        .idx    (rd_ptr_q),
        .en     (rd_acc),
        .onehot (rd_clr)
    );

    always_comb begin
        rd_ptr_d   = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d   = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        // Set and clear never hit the same entry: both accepted implies
        // 0 < count < 16, so wr_ptr != rd_ptr.
        valid_d    = (valid_q & ~rd_clr) | wr_en;
        overflow_d = overflow_q | (wr & full);
        count_d    = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + FIFO_CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - FIFO_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage; popped data is left in place, only valid drops.
    genvar k;
    generate
        for (k = 0; k < FIFO_DEPTH; k++) begin : g_entry
            logic [W-1:0] entry_q, entry_d;

            always_comb begin
                entry_d = wr_en[k] ? in : entry_q;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    entry_q <= '0;
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign out_flat[k*W +: W] = entry_q;
        end
    endgenerate

    assign valid    = valid_q;
    assign rd_ptr   = rd_ptr_q;
    assign wr_ptr   = wr_ptr_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule
